// File: rtl/elevator_scan_controller.sv
// Elevator SCAN sequencing controller: latches floor calls, moves the car
// one floor per travel interval and holds the door open at served floors.
module elevator_scan_controller #(
  parameter int NUM_FLOORS    = 8,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] req,
  output logic [3:0]            floor_bcd,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  typedef enum logic [1:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR_OPEN
  } state_t;

  localparam logic [15:0] TRAVEL_LAST = 16'(TRAVEL_CYCLES - 1);
  localparam logic [15:0] DOOR_LAST   = 16'(DOOR_CYCLES - 1);

  state_t                state, state_n, dec_state;
  logic                  dir_up, dir_up_n, dec_up;
  logic [15:0]           timer, timer_n;
  logic [3:0]            floor_n;
  logic [NUM_FLOORS-1:0] eff, fmask, pend_n;
  logic                  above, below, here, dec_here;
  logic                  here_req, up_hit, dn_hit;
  logic                  at_top, at_bot;

  always_comb begin
    eff   = pending | req;
    fmask = '0;
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      fmask[i] = (floor_bcd == 4'(i));
      if (eff[i] && (4'(i) > floor_bcd)) above = 1'b1;
      if (eff[i] && (4'(i) < floor_bcd)) below = 1'b1;
    end
    here     = |(eff & fmask);
    here_req = |(req & fmask);
    up_hit   = |(eff & (fmask << 1));
    dn_hit   = |(eff & (fmask >> 1));
    at_top   = fmask[NUM_FLOORS-1];
    at_bot   = fmask[0];
  end

  // Door expiry never re-serves its own floor, so only IDLE may pick "here".
  assign dec_here = here && (state == IDLE);

  always_comb begin
    dec_state = IDLE;
    dec_up    = dir_up;
    if (dec_here) begin
      dec_state = DOOR_OPEN;
    end else if (above && (dir_up || !below)) begin
      dec_state = MOVE_UP;
      dec_up    = 1'b1;
    end else if (below) begin
      dec_state = MOVE_DOWN;
      dec_up    = 1'b0;
    end
  end

  always_comb begin
    state_n  = state;
    dir_up_n = dir_up;
    timer_n  = timer;
    floor_n  = floor_bcd;
    pend_n   = eff;
    unique case (state)
      IDLE: begin
        timer_n  = '0;
        state_n  = dec_state;
        dir_up_n = dec_up;
        if (dec_state == DOOR_OPEN) pend_n = eff & ~fmask;
      end
      MOVE_UP: begin
        if (timer == TRAVEL_LAST) begin
          timer_n = '0;
          if (at_top) begin
            state_n = IDLE;
          end else begin
            floor_n = floor_bcd + 4'd1;
            if (up_hit) begin
              state_n = DOOR_OPEN;
              pend_n  = eff & ~(fmask << 1);
            end
          end
        end else begin
          timer_n = timer + 16'd1;
        end
      end
      MOVE_DOWN: begin
        if (timer == TRAVEL_LAST) begin
          timer_n = '0;
          if (at_bot) begin
            state_n = IDLE;
          end else begin
            floor_n = floor_bcd - 4'd1;
            if (dn_hit) begin
              state_n = DOOR_OPEN;
              pend_n  = eff & ~(fmask >> 1);
            end
          end
        end else begin
          timer_n = timer + 16'd1;
        end
      end
      DOOR_OPEN: begin
        // A call for the open floor only extends the door, never latches.
        pend_n = eff & ~fmask;
        if (here_req) begin
          timer_n = '0;
        end else if (timer == DOOR_LAST) begin
          timer_n  = '0;
          state_n  = dec_state;
          dir_up_n = dec_up;
        end else begin
          timer_n = timer + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      dir_up      <= 1'b1;
      timer       <= '0;
      floor_bcd   <= '0;
      pending     <= '0;
      moving_up   <= 1'b0;
      moving_down <= 1'b0;
      door_open   <= 1'b0;
    end else begin
      state       <= state_n;
      dir_up      <= dir_up_n;
      timer       <= timer_n;
      floor_bcd   <= floor_n;
      pending     <= pend_n;
      moving_up   <= (state_n == MOVE_UP);
      moving_down <= (state_n == MOVE_DOWN);
      door_open   <= (state_n == DOOR_OPEN);
    end
  end

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Scoreboard bench for elevator_scan_controller: a per-edge trip model
// feeds an expectation queue that a monitor drains after each edge.
module tb_elevator_scan_controller;

  localparam int NF     = 8;
  localparam int TRAVEL = 4;
  localparam int DOOR   = 3;

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_DOWN = 2;
  localparam int M_DOOR = 3;

  typedef struct packed {
    logic [3:0]    fl;
    logic          up;
    logic          dn;
    logic          dr;
    logic [NF-1:0] pd;
  } exp_t;

  logic          clk;
  logic          reset;
  logic [NF-1:0] req;
  logic [3:0]    floor_bcd;
  logic          moving_up;
  logic          moving_down;
  logic          door_open;
  logic [NF-1:0] pending;

  elevator_scan_controller #(
    .NUM_FLOORS(NF),
    .TRAVEL_CYCLES(TRAVEL),
    .DOOR_CYCLES(DOOR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .floor_bcd(floor_bcd),
    .moving_up(moving_up),
    .moving_down(moving_down),
    .door_open(door_open),
    .pending(pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  event chk_ev;

  // Trip model: countdown of cycles left in the current travel/door phase.
  int            m_floor;
  int            m_mode;
  int            m_left;
  bit            m_dir_up;
  logic [NF-1:0] m_pend;

  function automatic void m_reset();
    m_floor  = 0;
    m_mode   = M_IDLE;
    m_left   = 0;
    m_dir_up = 1'b1;
    m_pend   = '0;
  endfunction

  function automatic void m_decide(inout logic [NF-1:0] e,
                                   input bit allow_here);
    bit above;
    bit below;
    above = 1'b0;
    below = 1'b0;
    for (int j = 0; j < NF; j++) begin
      if (e[j] && j > m_floor) above = 1'b1;
      if (e[j] && j < m_floor) below = 1'b1;
    end
    if (allow_here && e[m_floor]) begin
      e[m_floor] = 1'b0;
      m_mode = M_DOOR;
      m_left = DOOR;
    end else if (above && (m_dir_up || !below)) begin
      m_dir_up = 1'b1;
      m_mode = M_UP;
      m_left = TRAVEL;
    end else if (below) begin
      m_dir_up = 1'b0;
      m_mode = M_DOWN;
      m_left = TRAVEL;
    end else begin
      m_mode = M_IDLE;
    end
  endfunction

  function automatic void m_step(input logic [NF-1:0] r);
    logic [NF-1:0] e;
    e = m_pend | r;
    case (m_mode)
      M_IDLE: m_decide(e, 1'b1);
      M_UP, M_DOWN: begin
        m_left--;
        if (m_left == 0) begin
          m_floor = (m_mode == M_UP) ? m_floor + 1 : m_floor - 1;
          if (e[m_floor]) begin
            e[m_floor] = 1'b0;
            m_mode = M_DOOR;
            m_left = DOOR;
          end else begin
            m_left = TRAVEL;
          end
        end
      end
      default: begin
        if (r[m_floor]) begin
          m_left = DOOR;
        end else begin
          m_left--;
          if (m_left == 0) m_decide(e, 1'b0);
        end
        e[m_floor] = 1'b0;
      end
    endcase
    m_pend = e;
  endfunction

  function automatic void push_exp();
    exp_t x;
    x.fl = 4'(m_floor);
    x.up = (m_mode == M_UP);
    x.dn = (m_mode == M_DOWN);
    x.dr = (m_mode == M_DOOR);
    x.pd = m_pend;
    exp_q.push_back(x);
  endfunction

  task automatic check(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  // Monitor: compare every queued expectation just after the DUT updates.
  initial begin
    exp_t x;
    exp_t a;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      while (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        a = {floor_bcd, moving_up, moving_down, door_open, pending};
        n_cmp++;
        if (a !== x) begin
          n_bad++;
          $display("FAIL outputs @%0t: got fl=%0d up=%b dn=%b door=%b pend=%b expected fl=%0d up=%b dn=%b door=%b pend=%b",
                   $time, a.fl, a.up, a.dn, a.dr, a.pd,
                   x.fl, x.up, x.dn, x.dr, x.pd);
        end
      end
    end
  end

  int   up_cnt, dn_cnt, door_cnt;
  int   door_q[$];
  logic prev_door;
  logic [3:0]    s_floor;
  logic [NF-1:0] s_pend;

  task automatic cyc(input logic [NF-1:0] r, input logic rst);
    @(negedge clk);
    up_cnt   += int'(moving_up);
    dn_cnt   += int'(moving_down);
    door_cnt += int'(door_open);
    if (door_open && !prev_door) door_q.push_back(int'(floor_bcd));
    prev_door = door_open;
    s_floor   = floor_bcd;
    s_pend    = pending;
    req   = r;
    reset = rst;
    @(posedge clk);
    if (reset) m_reset();
    else m_step(req);
    push_exp();
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    m_reset();
    push_exp();
    ->chk_ev;
    #2;
    check("rst_floor", int'(floor_bcd), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_flags", int'({moving_up, moving_down, door_open}), 0);
    prev_door = 1'b0;
    @(posedge clk);
    m_reset();
    push_exp();
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    do begin
      cyc('0, 1'b0);
      n++;
    end while (m_mode != M_IDLE && n < budget);
    if (m_mode != M_IDLE) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_wait: got %0d cycles without idle, required idle", n);
    end
  endtask

  task automatic run_until_floor(input int f, input int budget);
    int n;
    n = 0;
    while (m_floor != f && n < budget) begin
      cyc('0, 1'b0);
      n++;
    end
    if (m_floor != f) begin
      n_cmp++;
      n_bad++;
      $display("FAIL floor_wait: got floor %0d, required %0d", m_floor, f);
    end
  endtask

  task automatic run_until_door(input int budget);
    int n;
    n = 0;
    while (m_mode != M_DOOR && n < budget) begin
      cyc('0, 1'b0);
      n++;
    end
    if (m_mode != M_DOOR) begin
      n_cmp++;
      n_bad++;
      $display("FAIL door_wait: got mode %0d, required door", m_mode);
    end
  endtask

  function automatic void clear_stats();
    up_cnt   = 0;
    dn_cnt   = 0;
    door_cnt = 0;
    door_q.delete();
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NF-1:0] r;
    reset     = 1'b0;
    req       = '0;
    prev_door = 1'b0;
    clear_stats();
    m_reset();

    // Asynchronous reset before any clock edge, then hold idle.
    #2;
    assert_reset();
    cyc('0, 1'b1);
    cyc('0, 1'b0);
    cyc('0, 1'b0);

    // Single call to floor 3 from floor 0.
    clear_stats();
    cyc(NF'(1) << 3, 1'b0);
    run_idle(100);
    check("up_cycles", up_cnt, 12);
    check("door_cycles", door_cnt, DOOR);
    check("door_at", door_q.size() == 1 ? door_q[0] : -1, 3);
    cyc('0, 1'b0);
    check("idle_floor3", int'(s_floor), 3);

    // SCAN: heading for 5, a call at 1 arrives between floors 2 and 3.
    cyc('0, 1'b1);
    cyc('0, 1'b0);
    clear_stats();
    cyc(NF'(1) << 5, 1'b0);
    run_until_floor(2, 50);
    cyc('0, 1'b0);
    cyc(NF'(1) << 1, 1'b0);
    run_idle(200);
    check("scan_stops", door_q.size(), 2);
    if (door_q.size() == 2) begin
      check("scan_first", door_q[0], 5);
      check("scan_second", door_q[1], 1);
    end
    cyc('0, 1'b0);
    check("scan_end_floor", int'(s_floor), 1);

    // Same-floor call while idle at floor 4.
    cyc(NF'(1) << 4, 1'b0);
    run_idle(100);
    clear_stats();
    cyc(NF'(1) << 4, 1'b0);
    run_idle(50);
    check("same_moves", up_cnt + dn_cnt, 0);
    check("same_door", door_cnt, DOOR);
    check("same_at", door_q.size() == 1 ? door_q[0] : -1, 4);

    // Door extension at floor 2 on door cycle 2.
    cyc(NF'(1) << 2, 1'b0);
    run_until_door(50);
    clear_stats();
    cyc('0, 1'b0);
    cyc(NF'(1) << 2, 1'b0);
    cyc('0, 1'b0);
    check("ext_pend2", int'(s_pend[2]), 0);
    run_idle(50);
    check("ext_door", door_cnt, 5);

    // Top floor, then sweep to floor 0.
    cyc(NF'(1) << 7, 1'b0);
    run_idle(100);
    cyc('0, 1'b0);
    check("top_floor", int'(s_floor), 7);
    clear_stats();
    cyc(NF'(8'h81), 1'b0);
    run_idle(200);
    check("edge_stops", door_q.size(), 2);
    if (door_q.size() == 2) begin
      check("edge_first", door_q[0], 7);
      check("edge_second", door_q[1], 0);
    end
    cyc('0, 1'b0);
    check("bottom_floor", int'(s_floor), 0);

    // Reset mid-travel with calls outstanding.
    cyc(NF'(1) << 6, 1'b0);
    repeat (5) cyc('0, 1'b0);
    cyc(NF'(1) << 5, 1'b0);
    repeat (3) cyc('0, 1'b0);
    @(negedge clk);
    #2;
    assert_reset();
    cyc('0, 1'b1);
    cyc('0, 1'b0);

    // Random traffic with occasional asynchronous resets.
    repeat (2500) begin
      r = '0;
      case ($urandom_range(0, 9))
        0: r[$urandom_range(0, NF - 1)] = 1'b1;
        1: r = NF'($urandom) & NF'($urandom);
        default: r = '0;
      endcase
      if ($urandom_range(0, 499) == 0) begin
        @(negedge clk);
        #2;
        assert_reset();
        cyc('0, 1'b1);
        cyc('0, 1'b0);
      end else begin
        cyc(r, 1'b0);
      end
    end
    run_idle(500);

    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
